// File: rtl/md_issue_ctrl_if.sv
// md_issue_ctrl_if: decode-side request, flush, and MD unit handshake for md_issue_ctrl.
interface md_issue_ctrl_if;
    logic        d_valid;
    logic [3:0]  d_mdop;
    logic [31:0] d_a;
    logic [31:0] d_b;
    logic        e_flush;
    logic        md_busy;
    logic        md_en;
    logic [3:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        stall_d;
    logic        lat_err;
    modport master (
        input  d_valid, d_mdop, d_a, d_b, e_flush, md_busy,
        output md_en, md_op, md_a, md_b, stall_d, lat_err
    );
    modport slave (
        output d_valid, d_mdop, d_a, d_b, e_flush, md_busy,
        input  md_en, md_op, md_a, md_b, stall_d, lat_err
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issues multiply/divide-class ops to the MD unit and stalls decode while it is occupied.
module md_issue_ctrl (
    input logic             clk,
    input logic             reset,
    md_issue_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        lat_err_q, lat_err_d;
    logic        op_ok;
    assign op_ok = bus.d_mdop != 4'd0 && bus.d_mdop <= 4'd8;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        lat_err_d = lat_err_q;
        case (state_q)
            IDLE: if (bus.d_valid && !bus.md_busy && op_ok) begin
                op_d    = bus.d_mdop;
                a_d     = bus.d_a;
                b_d     = bus.d_b;
                state_d = ISSUE;
            end
            // mf/mt ops (5..8) finish in the issue cycle; a flushed op never reaches the unit
            ISSUE: if (bus.e_flush || op_q > 4'd4) state_d = IDLE;
            else begin
                state_d = RUN;
                cnt_d   = op_q <= 4'd2 ? 4'd5 : 4'd10;
            end
            RUN: begin
                cnt_d     = cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
                lat_err_d = lat_err_q | (cnt_q == 4'd0 && bus.md_busy) | (cnt_q >= 4'd2 && !bus.md_busy);
                if (cnt_q == 4'd0 && !bus.md_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            op_q      <= 4'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            lat_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            lat_err_q <= lat_err_d;
        end
    end
    assign bus.md_en   = state_q == ISSUE && !bus.e_flush;
    assign bus.md_op   = op_q;
    assign bus.md_a    = a_q;
    assign bus.md_b    = b_q;
    assign bus.lat_err = lat_err_q;
    assign bus.stall_d = bus.d_valid && op_ok && (state_q != IDLE || bus.md_busy);
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed scenarios checked every cycle against an elapsed-time occupancy model.
module tb_md_issue_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    md_issue_ctrl_if bus();
    md_issue_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;
    int en_cnt = 0;
    logic        m_pend = 1'b0;
    logic        m_run = 1'b0;
    logic        m_lat = 1'b0;
    int          m_el = 0;
    int          m_len = 0;
    logic [3:0]  m_op = 4'd0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;
    function automatic logic ok(input logic [3:0] op);
        return op != 4'd0 && op <= 4'd8;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend <= 1'b0;
            m_run  <= 1'b0;
            m_lat  <= 1'b0;
            m_el   <= 0;
            m_op   <= 4'd0;
            m_a    <= 32'd0;
            m_b    <= 32'd0;
        end else if (m_run) begin
            if ((m_el >= m_len && bus.md_busy) || (m_el + 2 <= m_len && !bus.md_busy)) m_lat <= 1'b1;
            if (m_el >= m_len && !bus.md_busy) m_run <= 1'b0;
            m_el <= m_el + 1;
        end else if (m_pend) begin
            m_pend <= 1'b0;
            if (!bus.e_flush && m_op <= 4'd4) begin
                m_run <= 1'b1;
                m_el  <= 0;
                m_len <= m_op <= 4'd2 ? 5 : 10;
            end
        end else if (bus.d_valid && !bus.md_busy && ok(bus.d_mdop)) begin
            m_pend <= 1'b1;
            m_op   <= bus.d_mdop;
            m_a    <= bus.d_a;
            m_b    <= bus.d_b;
        end
    end
    always @(negedge clk) begin
        chk("md_en", 32'(bus.md_en), 32'(m_pend && !bus.e_flush));
        chk("md_op", 32'(bus.md_op), 32'(m_op));
        chk("md_a", bus.md_a, m_a);
        chk("md_b", bus.md_b, m_b);
        chk("stall_d", 32'(bus.stall_d), 32'(bus.d_valid && ok(bus.d_mdop) && (m_pend || m_run || bus.md_busy)));
        chk("lat_err", 32'(bus.lat_err), 32'(m_lat));
    end
    task automatic cyc(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic f, input logic bz);
        @(posedge clk);
        #1;
        bus.d_valid = v;
        bus.d_mdop  = op;
        bus.d_a     = a;
        bus.d_b     = b;
        bus.e_flush = f;
        bus.md_busy = bz;
        @(negedge clk);
        stall_cnt += int'(bus.stall_d);
        en_cnt    += int'(bus.md_en);
    endtask
    task automatic clr();
        stall_cnt = 0;
        en_cnt    = 0;
    endtask
    initial begin
        bus.d_valid = 1'b0;
        bus.d_mdop  = 4'd0;
        bus.d_a     = 32'd0;
        bus.d_b     = 32'd0;
        bus.e_flush = 1'b0;
        bus.md_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_md_en", 32'(bus.md_en), 32'd0);
        chk("rst_md_op", 32'(bus.md_op), 32'd0);
        chk("rst_md_a", bus.md_a, 32'd0);
        chk("rst_lat_err", 32'(bus.lat_err), 32'd0);
        #1 reset = 1'b0;
        // first cycle after release: stall follows inputs only; reserved and nop ops ignored
        cyc(1'b1, 4'd2, 32'd1, 32'd1, 1'b0, 1'b1);
        chk("post_rst_stall_busy", 32'(bus.stall_d), 32'd1);
        cyc(1'b1, 4'd12, 32'd1, 32'd1, 1'b0, 1'b0);
        chk("reserved_no_stall", 32'(bus.stall_d), 32'd0);
        cyc(1'b1, 4'd0, 32'd1, 32'd1, 1'b0, 1'b0);
        chk("nop_no_stall", 32'(bus.stall_d), 32'd0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("reserved_no_issue", 32'(bus.md_en), 32'd0);
        chk("reserved_no_capture", 32'(bus.md_op), 32'd0);
        // mult with mfhi waiting in decode
        clr();
        cyc(1'b1, 4'd1, 32'd3, 32'hFFFF_FFFE, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("mult_md_en", 32'(bus.md_en), 32'd1);
        chk("mult_md_op", 32'(bus.md_op), 32'd1);
        chk("mult_md_a", bus.md_a, 32'd3);
        chk("mult_md_b", bus.md_b, 32'hFFFF_FFFE);
        repeat (5) cyc(1'b1, 4'd5, 32'd0, 32'd0, 1'b0, 1'b1);
        cyc(1'b1, 4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("mfhi_accepted_no_stall", 32'(bus.stall_d), 32'd0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("mult_stall_cycles", 32'(stall_cnt), 32'd7);
        chk("mult_en_pulses", 32'(en_cnt), 32'd2);
        chk("mult_md_op_mfhi", 32'(bus.md_op), 32'd5);
        chk("mult_lat_err", 32'(bus.lat_err), 32'd0);
        // div with mflo waiting
        clr();
        cyc(1'b1, 4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        cyc(1'b1, 4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("div_md_b", bus.md_b, 32'd7);
        repeat (10) cyc(1'b1, 4'd6, 32'd0, 32'd0, 1'b0, 1'b1);
        cyc(1'b1, 4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("div_last_run_stall", 32'(bus.stall_d), 32'd1);
        cyc(1'b1, 4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("div_stall_cycles", 32'(stall_cnt), 32'd12);
        chk("div_en_pulses", 32'(en_cnt), 32'd2);
        chk("div_lat_err", 32'(bus.lat_err), 32'd0);
        // flush during issue of divu
        clr();
        cyc(1'b1, 4'd4, 32'd5, 32'd6, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("flush_md_en", 32'(bus.md_en), 32'd0);
        cyc(1'b1, 4'd1, 32'd9, 32'd9, 1'b0, 1'b0);
        chk("flush_no_stall", 32'(bus.stall_d), 32'd0);
        chk("flush_op_held", 32'(bus.md_op), 32'd4);
        chk("flush_a_held", bus.md_a, 32'd5);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("post_flush_issue", 32'(bus.md_en), 32'd1);
        repeat (5) cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("flush_en_pulses", 32'(en_cnt), 32'd1);
        // MD unit stays busy longer than the mult latency
        clr();
        cyc(1'b1, 4'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (8) cyc(1'b1, 4'd5, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("late_lat_err", 32'(bus.lat_err), 32'd1);
        cyc(1'b1, 4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("late_stall_cycles", 32'(stall_cnt), 32'd10);
        chk("late_lat_sticky", 32'(bus.lat_err), 32'd1);
        // reset three cycles into a div
        cyc(1'b1, 4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        #1 reset = 1'b1;
        bus.md_busy = 1'b0;
        #1;
        chk("mid_rst_md_en", 32'(bus.md_en), 32'd0);
        chk("mid_rst_md_op", 32'(bus.md_op), 32'd0);
        chk("mid_rst_md_a", bus.md_a, 32'd0);
        chk("mid_rst_md_b", bus.md_b, 32'd0);
        chk("mid_rst_lat_err", 32'(bus.lat_err), 32'd0);
        chk("mid_rst_stall", 32'(bus.stall_d), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        clr();
        repeat (2) cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("aborted_no_en", 32'(en_cnt), 32'd0);
        cyc(1'b1, 4'd7, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("mthi_md_en", 32'(bus.md_en), 32'd1);
        chk("mthi_md_op", 32'(bus.md_op), 32'd7);
        chk("mthi_md_a", bus.md_a, 32'h1234_5678);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
